// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap sequencer: FSM state, default widths, tap-index modulo.
// Combinational helpers only; no timing or flow control.
package fir_pkg;

  localparam int FIR_DW    = 24;
  localparam int FIR_COEFW = 18;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // (base - k) mod ntaps for 0 <= base, k < ntaps; works for any ntaps, not just powers of two
  function automatic int tap_sub(input int base, input int k, input int ntaps);
    return (base >= k) ? (base - k) : (base + ntaps - k);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample input stream, paired a/b output streams and coefficient write port of the tap sequencer.
// master = stimulus/consumer side, slave = sequencer side.
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int COEFW = FIR_COEFW,
  parameter int AW    = 4
);
  logic signed [DW-1:0]    s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic signed [DW-1:0]    m_axis_atdata;
  logic                    m_axis_atvalid;
  logic                    m_axis_atready;
  logic                    m_axis_atlast;
  logic signed [COEFW-1:0] m_axis_btdata;
  logic                    m_axis_btvalid;
  logic                    m_axis_btready;
  logic                    coef_wr_en;
  logic [AW-1:0]           coef_wr_addr;
  logic signed [COEFW-1:0] coef_wr_data;

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_atready, m_axis_btready,
           coef_wr_en, coef_wr_addr, coef_wr_data,
    input  s_axis_tready, m_axis_atdata, m_axis_atvalid, m_axis_atlast,
           m_axis_btdata, m_axis_btvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_atready, m_axis_btready,
           coef_wr_en, coef_wr_addr, coef_wr_data,
    output s_axis_tready, m_axis_atdata, m_axis_atvalid, m_axis_atlast,
           m_axis_btdata, m_axis_btvalid
  );
endinterface

// File: rtl/fir_sample_ring.sv
// NTAPS-deep circular sample history with one write port and one async read port; tracks wptr and fill.
// Write takes effect at the clock edge; read is combinational; no flow control of its own.
module fir_sample_ring #(
  parameter int DW    = 24,
  parameter int NTAPS = 16,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_dat,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_dat,
  output logic [AW-1:0]        wptr,
  output logic [AW:0]          fill
);

  logic signed [DW-1:0] mem [NTAPS];

  // Contents are not reset: stale entries are masked by fill downstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      fill <= '0;
    end else if (wr_en) begin
      wptr <= (wptr == AW'(NTAPS - 1)) ? '0 : wptr + AW'(1);
      if (fill != (AW+1)'(NTAPS)) fill <= fill + (AW+1)'(1);
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Emits NTAPS (x[n-k], h[k]) pairs per accepted sample; pair 0 registered one cycle after accept, one pair/cycle.
// a/b streams handshake independently; a stall on either holds the pair, input ready only while idle.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int COEFW = FIR_COEFW,
  parameter int NTAPS = 16
) (
  input logic           clk,
  input logic           rst,
  fir_tap_sequencer_if.slave bus
);

  localparam int AW = $clog2(NTAPS);
  localparam logic [AW:0] LAST_K = (AW+1)'(NTAPS - 1);

  state_t                  state;
  logic [AW-1:0]           k;
  logic [AW-1:0]           base;
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rd_addr;
  logic [AW:0]             k_nxt;
  logic [AW:0]             fill;
  logic signed [DW-1:0]    rd_dat;
  logic signed [COEFW-1:0] coef [NTAPS];
  logic                    tready;
  logic                    a_vld;
  logic                    b_vld;
  logic                    a_last;
  logic signed [DW-1:0]    a_dat;
  logic signed [COEFW-1:0] b_dat;
  logic                    accept;
  logic                    a_ok;
  logic                    b_ok;

  assign accept  = tready && bus.s_axis_tvalid;
  assign a_ok    = !a_vld || bus.m_axis_atready;
  assign b_ok    = !b_vld || bus.m_axis_btready;
  assign k_nxt   = {1'b0, k} + (AW+1)'(1);
  assign rd_addr = AW'(tap_sub(int'(base), int'(k_nxt), NTAPS));

  fir_sample_ring #(
    .DW    (DW),
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_dat  (bus.s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat),
    .wptr    (wptr),
    .fill    (fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      k      <= '0;
      base   <= '0;
      tready <= 1'b0;
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      a_last <= 1'b0;
      a_dat  <= '0;
      b_dat  <= '0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < NTAPS))
        coef[bus.coef_wr_addr] <= bus.coef_wr_data;

      unique case (state)
        IDLE: begin
          tready <= 1'b1;
          if (accept) begin
            // The new sample is not in the ring until this edge, so pair 0 takes it straight from the input.
            tready <= 1'b0;
            base   <= wptr;
            k      <= '0;
            a_dat  <= bus.s_axis_tdata;
            b_dat  <= coef[0];
            a_last <= 1'b0;
            a_vld  <= 1'b1;
            b_vld  <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (a_vld && bus.m_axis_atready) a_vld <= 1'b0;
          if (b_vld && bus.m_axis_btready) b_vld <= 1'b0;
          if (a_ok && b_ok) begin
            if ({1'b0, k} == LAST_K) begin
              state  <= IDLE;
              tready <= 1'b1;
              a_last <= 1'b0;
            end else begin
              k      <= k_nxt[AW-1:0];
              a_dat  <= (k_nxt < fill) ? rd_dat : '0;
              b_dat  <= coef[k_nxt[AW-1:0]];
              a_last <= (k_nxt == LAST_K);
              a_vld  <= 1'b1;
              b_vld  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready  = tready;
  assign bus.m_axis_atdata  = a_dat;
  assign bus.m_axis_atvalid = a_vld;
  assign bus.m_axis_atlast  = a_last;
  assign bus.m_axis_btdata  = b_dat;
  assign bus.m_axis_btvalid = b_vld;

endmodule
